// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, issues one word read at a time to
// instruction memory and buffers responses in a prefetch FIFO presented to the decoder.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instruction_RDY_BSY,
  input  logic        instr_ack,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    BUF_FULL
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             discard_q, discard_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_after_pop;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             rdy_q, rdy_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      ipc_q, ipc_d;

  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem   [FIFO_DEPTH];

  logic             outstanding, outstanding_next;
  logic             granted, push, pop;

  // A response is in flight either in FETCH_WAIT or while a flushed one is still owed.
  assign outstanding      = (state_q == FETCH_WAIT) | discard_q;
  assign granted          = req_q & imem_gnt;
  assign outstanding_next = (outstanding & ~imem_rvalid) | granted;
  assign push             = imem_rvalid & outstanding & ~discard_q & ~redirect_valid;
  assign pop              = rdy_q & instr_ack & ~redirect_valid;
  assign cnt_after_pop    = cnt_q - CNT_W'(pop);

  always_comb begin
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    fetch_pc_d = granted ? fetch_pc_q + 32'd4 : fetch_pc_q;
    req_pc_d   = granted ? fetch_pc_q : req_pc_q;
    discard_d  = discard_q & ~imem_rvalid;
    state_d    = state_q;

    if (redirect_valid) begin
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc & ~32'h3;
      discard_d  = outstanding_next;
      state_d    = FETCH_REQ;
    end else if (outstanding_next) begin
      state_d = discard_d ? FETCH_REQ : FETCH_WAIT;
    end else begin
      state_d = (cnt_d < DEPTH_C) ? FETCH_REQ : BUF_FULL;
    end

    // A flushed response must return before a new request goes out.
    req_d = (state_d == FETCH_REQ) & ~discard_d;

    rdy_d   = 1'b0;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (cnt_d != '0) begin
      rdy_d = 1'b1;
      if (cnt_after_pop == '0) begin
        instr_d = imem_rdata;
        ipc_d   = req_pc_q;
      end else begin
        instr_d = data_mem[rd_ptr_d];
        ipc_d   = pc_mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      discard_q  <= 1'b0;
      req_q      <= 1'b0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rdy_q      <= 1'b0;
      instr_q    <= '0;
      ipc_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rdy_q      <= rdy_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign imem_req            = req_q;
  assign imem_addr           = fetch_pc_q;
  assign instruction         = instr_q;
  assign instr_pc            = ipc_q;
  assign instruction_RDY_BSY = rdy_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the RISC-V decoder. It holds the fetch PC, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned words in a small prefetch FIFO. It presents the head entry to the decoder as instruction plus instruction_RDY_BSY. Control-flow redirects flush the FIFO and restart fetch at a new PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset (bits [1:0] must be 0)
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word-aligned read address, valid while imem_req=1
imem_gnt  input  1  memory accepted request this cycle (meaningful only when imem_req=1)
imem_rvalid  input  1  read data valid, exactly one per granted request, >=1 cycle after gnt
imem_rdata  input  32  instruction word
instruction  output  32  head-of-FIFO instruction to decoder
instr_pc  output  32  PC of presented instruction
instruction_RDY_BSY  output  1  1: instruction valid/ready, 0: busy/none
instr_ack  input  1  decoder consumes presented instruction (ignored when RDY_BSY=0)
redirect_valid  input  1  branch/jump redirect, one-cycle pulse
redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0 internally

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; FIFO empty; state=FETCH_REQ; discard flag=0; imem_req=0, imem_addr=RESET_PC, instruction=0, instr_pc=0, instruction_RDY_BSY=0. First imem_req=1 in the first cycle after rst deasserts. Reset mid-transaction abandons any outstanding response (memory assumed reset together).
- At most one outstanding request. Entries counted = FIFO count + outstanding(0/1). Request is issued only when count < FIFO_DEPTH.
- FSM:
  FETCH_REQ: imem_req=1, imem_addr=fetch_pc. On gnt: fetch_pc<=fetch_pc+4 (wraps 32'hFFFF_FFFC->0), go FETCH_WAIT.
  FETCH_WAIT: imem_req=0. On rvalid: if discard=0, push {rdata, pc} into FIFO; else drop word and clear discard. Next: FETCH_REQ if space remains after this cycle's push/pop, else BUF_FULL.
  BUF_FULL: imem_req=0. When an ack pops an entry, go FETCH_REQ next cycle.
- imem_req must not drop while waiting for gnt unless a redirect occurs. Address then changes to redirect_pc the next cycle, with req held.
- Output: instruction/instr_pc/RDY_BSY are registered from FIFO head. A word arriving on rvalid into an empty FIFO appears with RDY_BSY=1 the next cycle (1-cycle latency). RDY_BSY stays 1 and data is stable until a cycle with instr_ack=1. Then the next entry (or RDY_BSY=0) appears the following cycle.
- Simultaneous push and pop in the same cycle: both performed; count unchanged.
- Redirect (highest priority): FIFO flushed; RDY_BSY=0 next cycle; a same-cycle ack is ignored; fetch_pc<=redirect_pc&~3; state<=FETCH_REQ.
  - If a response is outstanding (FETCH_WAIT, or gnt in the redirect cycle), discard<=1 and the next rvalid is dropped. The new request is not issued until that response returns, which keeps a single outstanding request.
  - A rvalid in the redirect cycle itself is dropped.
- Instruction outputs hold their last value when RDY_BSY=0. Only RDY_BSY qualifies them.

Test Plan:
- Reset RESET_PC=0x100, memory grants immediately, rvalid 1 cycle after gnt, decoder acks every valid -> addresses 0x100,0x104,0x108… in order; instr_pc matches; rdata=0x00A00093 presented with RDY_BSY=1 one cycle after its rvalid.
- Decoder never acks -> exactly FIFO_DEPTH=2 requests (0x0,0x4) then imem_req=0 in BUF_FULL; a single ack -> one more request to 0x8 the next cycle.
- Redirect to 0x203 while FETCH_WAIT for 0x8 -> 0x8 response dropped, FIFO empty, next imem_addr=0x200, first presented instr_pc=0x200.
- Redirect and instr_ack in the same cycle with 2 entries buffered -> RDY_BSY=0 next cycle, no entry delivered, fetch resumes at redirect_pc.
- Memory withholds gnt 5 cycles -> imem_req and imem_addr stable throughout; fetch_pc wrap test: RESET_PC=0xFFFFFFFC -> second request address 0x00000000.
- rst pulled low mid-FETCH_WAIT -> all outputs at reset values immediately (asynchronously); after release, fetch restarts at RESET_PC.
